onchip_mem_reader: RTL

ONCHIP_MEM_READER -- requirements
Module: onchip_mem_reader

---
 rtl/onchip_mem_reader_pkg.sv | 19 +
 rtl/onchip_mem_reader_unpack.sv | 60 ++++++
 rtl/onchip_mem_reader.sv | 138 +++++++++++++
 3 files changed

// File: rtl/onchip_mem_reader_pkg.sv
// Purpose : shared types and constants for the on-chip memory reader.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package onchip_mem_reader_pkg;

    // Reader control states.
    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN,
        FIN
    } state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 8 * BYTES_PER_WORD;
    localparam int BIDX_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/onchip_mem_reader_unpack.sv
// Purpose : captures one bus word and serialises it little-endian onto a byte stream.
// Latency : captured word presents its first byte the cycle after cap_i.
// Backpressure: st_valid_o/st_data_o hold until st_ready_i; one byte per handshake.
// Ports: cap_i/word_i load a new word; st_* is the byte stream;
//        last_acc_o pulses when the final byte of the word is accepted.
module onchip_mem_reader_unpack
    import onchip_mem_reader_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cap_i,
    input  logic [WORD_W-1:0] word_i,
    input  logic              st_ready_i,
    output logic [7:0]        st_data_o,
    output logic              st_valid_o,
    output logic              last_acc_o
);

    logic [WORD_W-1:0] word_q, word_d;
    logic [BIDX_W-1:0] idx_q, idx_d;
    logic              vld_q, vld_d;
    logic              last_byte;

    assign last_byte = (idx_q == BIDX_W'(BYTES_PER_WORD - 1));

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        vld_d  = vld_q;
        if (cap_i) begin
            word_d = word_i;
            idx_d  = '0;
            vld_d  = 1'b1;
        end else if (vld_q && st_ready_i) begin
            // Index wraps to 0 after the last byte, ready for the next word.
            idx_d = idx_q + 1'b1;
            if (last_byte) begin
                vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            word_q <= '0;
            idx_q  <= '0;
            vld_q  <= 1'b0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
            vld_q  <= vld_d;
        end
    end

    // Byte select straight from registers, so data is stable while stalled.
    assign st_data_o  = word_q[{idx_q, 3'b000} +: 8];
    assign st_valid_o = vld_q;
    assign last_acc_o = vld_q && st_ready_i && last_byte;

endmodule

// File: rtl/onchip_mem_reader.sv
// Purpose : reads num_words words from an Avalon-MM slave and streams them out as bytes.
// Latency : start->m_read 1 cycle; m_readdatavalid->st_valid 1 cycle; one read outstanding.
// Backpressure: m_waitrequest holds the request; st_ready low stalls the byte stream.
// Ports: start/base_addr/num_words command; busy/done status; m_* Avalon-MM read master;
//        st_* byte stream; checksum valid while done is high.
// Option: define ONCHIP_MEM_READER_CHECKSUM_EN for the modulo-256 byte checksum,
//         otherwise checksum reads 8'h00.
module onchip_mem_reader
    import onchip_mem_reader_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  num_words,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    output logic [3:0]        m_byteenable,
    input  logic              m_waitrequest,
    input  logic [31:0]       m_readdata,
    input  logic              m_readdatavalid,
    output logic [7:0]        st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic [7:0]        checksum
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;   // words not yet requested
    logic              cap;
    logic              last_acc;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_words != '0) begin
                        state_d = REQ;
                        addr_d  = base_addr;
                        rem_d   = num_words;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            REQ: begin
                if (!m_waitrequest) begin
                    state_d = WAIT;
                    rem_d   = rem_q - 1'b1;
                end
            end
            WAIT: begin
                if (m_readdatavalid) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (last_acc) begin
                    if (rem_q != '0) begin
                        state_d = REQ;
                        addr_d  = addr_q + 1'b1;  // wraps at 2^ADDR_W
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
        end
    end

    assign m_read       = (state_q == REQ);
    assign m_address    = addr_q;
    assign m_byteenable = 4'hF;
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == FIN);

    // Read data is only honoured in WAIT; stray or post-reset beats are dropped.
    assign cap = (state_q == WAIT) && m_readdatavalid;

    onchip_mem_reader_unpack u_unpack (
        .clk        (clk),
        .reset_n    (reset_n),
        .cap_i      (cap),
        .word_i     (m_readdata),
        .st_ready_i (st_ready),
        .st_data_o  (st_data),
        .st_valid_o (st_valid),
        .last_acc_o (last_acc)
    );

`ifdef ONCHIP_MEM_READER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if ((state_q == IDLE) && start) begin
            csum_d = '0;
        end else if (st_valid && st_ready) begin
            csum_d = csum_q + st_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = 8'h00;
`endif

endmodule
